// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared response codes, FSM encodings and the address window check
// for the AXI4-Lite SRAM slave.
package axi4_lite_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // 33-bit limit so a window ending exactly at 2^32 does not wrap to zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] limit;
    limit = {1'b0, base} + span;
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/axi4_lite_sram_slave_sram_byte_array.sv
// DEPTH_WORDS x 32 SRAM, one synchronous read port and one byte-lane write port.
// Reads see the contents from before a same-edge write; only the read register clears.
module sram_byte_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic             i_rd_clr,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_be,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_rd_clr) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wr_en && i_wr_be[b]) begin
        r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave memory with independent read and write FSMs,
// programmable latencies and SLVERR on accesses outside the window.
module axi4_lite_sram_slave
  import axi4_lite_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 1,
  parameter int          WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int RCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WCNT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD  = RCNT_W'(RD_LAT - 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD  = WCNT_W'(WR_LAT - 1);
  localparam logic [32:0]       SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  rd_state_t         r_rd_state, w_rd_state_nx;
  logic [31:0]       r_araddr, w_araddr_nx;
  logic [RCNT_W-1:0] r_rcnt, w_rcnt_nx;
  logic              r_arready, w_arready_nx;
  logic              r_rvalid, w_rvalid_nx;
  logic [1:0]        r_rresp, w_rresp_nx;
  logic              w_rd_capture;
  logic              w_rd_in_range;
  logic [IDX_W-1:0]  w_rd_idx;

  wr_state_t         r_wr_state, w_wr_state_nx;
  logic [31:0]       r_awaddr, w_awaddr_nx;
  logic [31:0]       r_wdata, w_wdata_nx;
  logic [3:0]        r_wstrb, w_wstrb_nx;
  logic              r_have_aw, w_have_aw_nx;
  logic              r_have_w, w_have_w_nx;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nx;
  logic              r_awready, w_awready_nx;
  logic              r_wready, w_wready_nx;
  logic              r_bvalid, w_bvalid_nx;
  logic [1:0]        r_bresp, w_bresp_nx;
  logic              w_aw_hs, w_w_hs;
  logic              w_wr_commit;
  logic              w_wr_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [31:0]       w_sram_rdata;

  assign w_rd_in_range = addr_in_range(r_araddr, BASE_ADDR, SPAN_BYTES);
  assign w_wr_in_range = addr_in_range(r_awaddr, BASE_ADDR, SPAN_BYTES);
  assign w_rd_idx      = IDX_W'((r_araddr - BASE_ADDR) >> 2);
  assign w_wr_idx      = IDX_W'((r_awaddr - BASE_ADDR) >> 2);
  assign w_aw_hs       = awvalid && r_awready;
  assign w_w_hs        = wvalid && r_wready;

  always_comb begin
    w_rd_state_nx = r_rd_state;
    w_araddr_nx   = r_araddr;
    w_rcnt_nx     = r_rcnt;
    w_arready_nx  = r_arready;
    w_rvalid_nx   = r_rvalid;
    w_rresp_nx    = r_rresp;
    w_rd_capture  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        // arready is still low on the first cycle out of reset
        if (!r_arready) begin
          w_arready_nx = 1'b1;
        end else if (arvalid) begin
          w_araddr_nx   = araddr;
          w_rcnt_nx     = RCNT_LOAD;
          w_arready_nx  = 1'b0;
          w_rd_state_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_rcnt == '0) begin
          w_rd_capture  = !rst;
          w_rvalid_nx   = 1'b1;
          w_rresp_nx    = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
          w_rd_state_nx = R_RESP;
        end else begin
          w_rcnt_nx = r_rcnt - RCNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) begin
          w_rvalid_nx   = 1'b0;
          w_arready_nx  = 1'b1;
          w_rd_state_nx = R_IDLE;
        end
      end
      default: w_rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_araddr   <= '0;
      r_rcnt     <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= '0;
    end else begin
      r_rd_state <= w_rd_state_nx;
      r_araddr   <= w_araddr_nx;
      r_rcnt     <= w_rcnt_nx;
      r_arready  <= w_arready_nx;
      r_rvalid   <= w_rvalid_nx;
      r_rresp    <= w_rresp_nx;
    end
  end

  always_comb begin
    w_wr_state_nx = r_wr_state;
    w_awaddr_nx   = r_awaddr;
    w_wdata_nx    = r_wdata;
    w_wstrb_nx    = r_wstrb;
    w_have_aw_nx  = r_have_aw;
    w_have_w_nx   = r_have_w;
    w_wcnt_nx     = r_wcnt;
    w_awready_nx  = r_awready;
    w_wready_nx   = r_wready;
    w_bvalid_nx   = r_bvalid;
    w_bresp_nx    = r_bresp;
    w_wr_commit   = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (!r_awready && !r_have_aw) w_awready_nx = 1'b1;
        if (!r_wready && !r_have_w)   w_wready_nx  = 1'b1;
        if (w_aw_hs) begin
          w_awaddr_nx  = awaddr;
          w_have_aw_nx = 1'b1;
          w_awready_nx = 1'b0;
        end
        if (w_w_hs) begin
          w_wdata_nx  = wdata;
          w_wstrb_nx  = wstrb;
          w_have_w_nx = 1'b1;
          w_wready_nx = 1'b0;
        end
        // Latency counts from whichever beat completes the pair
        if ((r_have_aw || w_aw_hs) && (r_have_w || w_w_hs)) begin
          w_wcnt_nx     = WCNT_LOAD;
          w_wr_state_nx = W_WAIT;
        end
      end
      W_WAIT: begin
        if (r_wcnt == '0) begin
          w_wr_commit   = !rst;
          w_bvalid_nx   = 1'b1;
          w_bresp_nx    = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
          w_wr_state_nx = W_RESP;
        end else begin
          w_wcnt_nx = r_wcnt - WCNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_bvalid_nx   = 1'b0;
          w_awready_nx  = 1'b1;
          w_wready_nx   = 1'b1;
          w_have_aw_nx  = 1'b0;
          w_have_w_nx   = 1'b0;
          w_wr_state_nx = W_IDLE;
        end
      end
      default: w_wr_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_have_aw  <= 1'b0;
      r_have_w   <= 1'b0;
      r_wcnt     <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= '0;
    end else begin
      r_wr_state <= w_wr_state_nx;
      r_awaddr   <= w_awaddr_nx;
      r_wdata    <= w_wdata_nx;
      r_wstrb    <= w_wstrb_nx;
      r_have_aw  <= w_have_aw_nx;
      r_have_w   <= w_have_w_nx;
      r_wcnt     <= w_wcnt_nx;
      r_awready  <= w_awready_nx;
      r_wready   <= w_wready_nx;
      r_bvalid   <= w_bvalid_nx;
      r_bresp    <= w_bresp_nx;
    end
  end

  sram_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk       (clk),
    .i_rd_en   (w_rd_capture && w_rd_in_range),
    .i_rd_clr  (rst || (w_rd_capture && !w_rd_in_range)),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_sram_rdata),
    .i_wr_en   (w_wr_commit && w_wr_in_range),
    .i_wr_be   (r_wstrb),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (r_wdata)
  );

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = w_sram_rdata;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

endmodule
